// File: rtl/encoder_pri_16_4_hs_pkg.sv
// Shared constants and FSM state type for the 16-to-4 handshake priority encoder.
package encoder_pri_16_4_hs_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CODE_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/encoder_pri_16_4_hs_if.sv
// Request/code handshake bundle between event sources, the encoder and its consumer.
interface encoder_pri_16_4_hs_if;
  import encoder_pri_16_4_hs_pkg::*;

  logic              en_in;
  logic [WIDTH-1:0]  req_in;
  logic              ready_in;
  logic [CODE_W-1:0] code_out;
  logic              valid_out;
  logic [WIDTH-1:0]  pend_out;
  logic              ovf_out;

  modport master (
    input  en_in, req_in, ready_in,
    output code_out, valid_out, pend_out, ovf_out
  );

  modport slave (
    output en_in, req_in, ready_in,
    input  code_out, valid_out, pend_out, ovf_out
  );

endinterface

// File: rtl/encoder_pri_16_4_hs_pri_sel_comb.sv
// Combinational finder: first set bit of cand searching downward from start, wrapping modulo WIDTH.
module encoder_pri_16_4_hs_pri_sel_comb
  import encoder_pri_16_4_hs_pkg::*;
(
  input  logic [WIDTH-1:0]  cand_i,
  input  logic [CODE_W-1:0] start_i,
  output logic [CODE_W-1:0] idx_c_o,
  output logic              any_c_o
);

  logic [CODE_W-1:0] pos;

  always_comb begin
    idx_c_o = '0;
    any_c_o = 1'b0;
    pos     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pos = start_i - CODE_W'(i);
      if (!any_c_o && cand_i[pos]) begin
        idx_c_o = pos;
        any_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_pri_16_4_hs.sv
// Sticky-pending 16-to-4 priority encoder with valid/ready code output.
// Define ENCODER_RR_EN for round-robin selection; default is fixed priority (bit 15 highest).
module encoder_pri_16_4_hs
  import encoder_pri_16_4_hs_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  encoder_pri_16_4_hs_if.master bus
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic              accept_c;
  logic [WIDTH-1:0]  clr_c;
  logic [WIDTH-1:0]  kept_c;
  logic [WIDTH-1:0]  cand_c;
  logic [CODE_W-1:0] start_c;
  logic [CODE_W-1:0] sel_idx_c;
  logic              sel_any_c;

  // The accepted bit is cleared before new requests are OR-ed in, so a same-cycle re-request wins.
  assign accept_c = valid_q & bus.ready_in;
  assign clr_c    = accept_c ? (WIDTH'(1) << code_q) : '0;
  assign kept_c   = pend_q & ~clr_c;
  assign cand_c   = kept_c | bus.req_in;

`ifdef ENCODER_RR_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;

  // On accept the search already starts just below the accepted index, so back-to-back loads rotate.
  assign start_c = accept_c ? (code_q - CODE_W'(1)) : ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_c && !bus.en_in) begin
      ptr_d = code_q - CODE_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q <= CODE_W'(WIDTH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_c = CODE_W'(WIDTH - 1);
`endif

  encoder_pri_16_4_hs_pri_sel_comb u_sel (
    .cand_i  (cand_c),
    .start_i (start_c),
    .idx_c_o (sel_idx_c),
    .any_c_o (sel_any_c)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    pend_d  = bus.en_in ? kept_c : cand_c;
    ovf_d   = ~bus.en_in & (|(bus.req_in & kept_c));
    case (state_q)
      IDLE: begin
        if (!bus.en_in && sel_any_c) begin
          code_d  = sel_idx_c;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (accept_c) begin
          if (!bus.en_in && sel_any_c) begin
            code_d = sel_idx_c;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.code_out  = code_q;
  assign bus.valid_out = valid_q;
  assign bus.pend_out  = pend_q;
  assign bus.ovf_out   = ovf_q;

endmodule
